// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with 2-flop synchronizer, optional parity and multi-stop-bit checking.
module uart_rx #(
  parameter int P_UART_CLK        = 250_000_000,
  parameter int P_UART_BAUDRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_usr_rx_data,
  output logic                         o_usr_rx_valid,
  output logic                         o_rx_check_err,
  output logic                         o_rx_frame_err
);
  localparam int D  = P_UART_CLK / P_UART_BAUDRATE;
  localparam int H  = D / 2;
  localparam int HM = H > 0 ? H - 1 : 0;
  localparam int CW = D > 1 ? $clog2(D) : 1;
  localparam int NB = P_UART_DATA_WIDTH > P_UART_STOP_WIDTH ? P_UART_DATA_WIDTH : P_UART_STOP_WIDTH;
  localparam int BW = $clog2(NB + 1);
  localparam int DW = P_UART_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, START, DATA, CHECK, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic [DW-1:0]   data_q, data_d;
  logic            sync1_q, sync2_q, prev_q;
  logic            cerr_q, cerr_d, ferr_q, ferr_d;
  logic            valid_q, valid_d, ocerr_q, ocerr_d, oferr_q, oferr_d;
  logic            bit_end, par_x;

  assign bit_end = cnt_q == CW'(D - 1);
  assign par_x   = ^sh_q ^ sync2_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ocerr_q <= 1'b0;
      oferr_q <= 1'b0;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cerr_q  <= cerr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ocerr_q <= ocerr_d;
      oferr_q <= oferr_d;
    end
  end

  // Bit timing: START samples at H-1, every later state samples at D-1 with the counter restarted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    cerr_d  = cerr_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ocerr_d = ocerr_q;
    oferr_d = oferr_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        cerr_d = 1'b0;
        ferr_d = 1'b0;
        if (prev_q && !sync2_q) state_d = START;
      end
      START: if (cnt_q == CW'(HM)) begin
        cnt_d   = '0;
        state_d = sync2_q ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_d = '0;
        sh_d  = (sh_q >> 1) | (DW'(sync2_q) << (DW - 1));
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(DW - 1)) begin
          bit_d   = '0;
          state_d = P_UART_CHECK > 0 ? CHECK : STOP;
        end
      end
      CHECK: if (bit_end) begin
        cnt_d   = '0;
        cerr_d  = P_UART_CHECK == 1 ? ~par_x : P_UART_CHECK == 2 ? par_x : 1'b0;
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        cnt_d  = '0;
        bit_d  = bit_q + BW'(1);
        ferr_d = ferr_q | ~sync2_q;
        if (bit_q == BW'(P_UART_STOP_WIDTH - 1)) begin
          state_d = IDLE;
          valid_d = 1'b1;
          data_d  = sh_q;
          ocerr_d = cerr_q;
          oferr_d = ferr_q | ~sync2_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_usr_rx_data  = data_q;
  assign o_usr_rx_valid = valid_q;
  assign o_rx_check_err = ocerr_q;
  assign o_rx_frame_err = oferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench driving three receiver configurations (no parity, odd, even/2 stop).
module tb_uart_rx;
  localparam int D = 434;
  localparam int H = 217;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       c;
    logic       f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx = 3'b111;
  logic [2:0] vld, cerr, ferr, pv;
  logic [7:0] dat [3];
  exp_t       sb[$];
  exp_t       e;
  int         total = 0, passed = 0, cyc = 0;
  int         npulse[3] = '{0, 0, 0};
  int         vcyc[3] = '{0, 0, 0};
  int         st, lat;

  always #1 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.P_UART_CLK(50_000_000), .P_UART_BAUDRATE(115200), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[0]), .o_usr_rx_data(dat[0]),
    .o_usr_rx_valid(vld[0]), .o_rx_check_err(cerr[0]), .o_rx_frame_err(ferr[0]));
  uart_rx #(.P_UART_CLK(50_000_000), .P_UART_BAUDRATE(115200), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[1]), .o_usr_rx_data(dat[1]),
    .o_usr_rx_valid(vld[1]), .o_rx_check_err(cerr[1]), .o_rx_frame_err(ferr[1]));
  uart_rx #(.P_UART_CLK(50_000_000), .P_UART_BAUDRATE(115200), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(2), .P_UART_CHECK(2)) u2 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[2]), .o_usr_rx_data(dat[2]),
    .o_usr_rx_valid(vld[2]), .o_rx_check_err(cerr[2]), .o_rx_frame_err(ferr[2]));

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic bitk(int k, logic b);
    rx[k] = b;
    repeat (D) @(negedge clk);
  endtask

  task automatic frame(int k, logic [7:0] d, bit has_par, logic p, logic s1, logic s2, int ns);
    bitk(k, 1'b0);
    for (int i = 0; i < 8; i++) bitk(k, d[i]);
    if (has_par) bitk(k, p);
    bitk(k, s1);
    if (ns == 2) bitk(k, s2);
  endtask

  task automatic push(int k, logic [7:0] d, logic c, logic f);
    exp_t x;
    x.k = k; x.d = d; x.c = c; x.f = f;
    sb.push_back(x);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 2 * D && sb.size() != 0; i++) @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pv[k]) chk("pulse_width", int'(vld[k]), 0);
      if (vld[k]) begin
        npulse[k]++;
        vcyc[k] = cyc;
        if (sb.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("dut_id", k, e.k);
          chk("data", int'(dat[k]), int'(e.d));
          chk("check_err", int'(cerr[k]), int'(e.c));
          chk("frame_err", int'(ferr[k]), int'(e.f));
        end
      end
    end
    pv = vld;
  end

  initial begin
    pv = '0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_outputs", int'({vld[k], cerr[k], ferr[k], dat[k]}), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    st = cyc;
    push(0, 8'hA5, 1'b0, 1'b0);
    frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    drain("drain_a5");
    lat = vcyc[0] - st;
    chk("a5_latency_window", int'(lat >= 9 * D + H && lat <= 9 * D + H + 6), 1);
    chk("a5_pulses", npulse[0], 1);
    repeat (D) @(negedge clk);

    push(1, 8'h03, 1'b0, 1'b0);
    frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    push(1, 8'h03, 1'b1, 1'b0);
    frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    drain("drain_odd");
    chk("odd_pulses", npulse[1], 2);

    push(2, 8'hFF, 1'b0, 1'b1);
    frame(2, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    drain("drain_even");
    repeat (3 * 12 * D) @(negedge clk);
    chk("break_pulses", npulse[2], 1);
    rx[2] = 1'b1;
    repeat (D) @(negedge clk);

    rx[0] = 1'b0;
    repeat (100) @(negedge clk);
    rx[0] = 1'b1;
    repeat (2 * D) @(negedge clk);
    chk("glitch_pulses", npulse[0], 1);
    push(0, 8'h5A, 1'b0, 1'b0);
    frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    drain("drain_5a");
    chk("5a_pulses", npulse[0], 2);
    repeat (D) @(negedge clk);

    push(0, 8'h00, 1'b0, 1'b0);
    push(0, 8'hFF, 1'b0, 1'b0);
    push(0, 8'h81, 1'b0, 1'b0);
    frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    drain("drain_b2b");
    chk("b2b_pulses", npulse[0], 5);
    repeat (D) @(negedge clk);

    bitk(0, 1'b0);
    for (int i = 0; i < 4; i++) bitk(0, i[0]);
    rx[0] = 1'b1;
    repeat (H / 2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("midframe_reset_outputs", int'({vld[0], cerr[0], ferr[0], dat[0]}), 0);
    rst = 1'b0;
    repeat (2 * D) @(negedge clk);
    chk("abort_pulses", npulse[0], 5);
    push(0, 8'h3C, 1'b0, 1'b0);
    frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    drain("drain_3c");
    chk("3c_pulses", npulse[0], 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- P_UART_CLK, 250_000_000, i_clk frequency in Hz.
- P_UART_BAUDRATE, 9600, line bit rate.
- P_UART_DATA_WIDTH, 8, data bits per frame.
- P_UART_STOP_WIDTH, 1, stop bits per frame.
- P_UART_CHECK, 0, parity mode: 0 none, 1 odd, 2 even.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_uart_rx, in, 1, asynchronous serial line; idles high.
- o_usr_rx_data, out, P_UART_DATA_WIDTH, received data word.
- o_usr_rx_valid, out, 1, one-cycle strobe; data and flags are valid in this cycle.
- o_rx_check_err, out, 1, parity mismatch for the current frame; meaningful only when valid is high.
- o_rx_frame_err, out, 1, at least one stop bit sampled low; meaningful only when valid is high.

Function
REQ-003 Bit period SHALL be D = P_UART_CLK / P_UART_BAUDRATE cycles, using integer division.
REQ-004 Half period SHALL be H = D / 2, using integer division.
REQ-005 The bit-period counter SHALL be wide enough to hold D-1.
REQ-006 i_uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-007 The FSM SHALL have the states IDLE, START, DATA, CHECK and STOP.
REQ-008 IDLE -> START SHALL occur on a synchronized falling edge (previous sample 1, current sample 0).
REQ-009 A low level without a preceding high sample SHALL NOT start a frame.
REQ-010 In START, the line SHALL be sampled H cycles after the edge.
- Sample 0: go to DATA and restart the bit counter.
- Sample 1: false start; return to IDLE with no valid strobe.
REQ-011 In DATA, the line SHALL be sampled every D cycles after the start-bit sample.
- Bits are shifted in LSB first.
- Exactly P_UART_DATA_WIDTH bits are taken.
- Then go to CHECK if P_UART_CHECK>0, otherwise to STOP.
REQ-012 CHECK SHALL sample one parity bit D cycles after the last data bit.
- Mode 1 (odd): error when the XOR of data and parity is 0.
- Mode 2 (even): error when the XOR of data and parity is 1.
REQ-013 STOP SHALL sample P_UART_STOP_WIDTH bits, each D cycles apart.
- Any 0 sample sets the frame error for this frame.
REQ-014 The cycle after the final stop-bit sample, the block SHALL:
- pulse o_usr_rx_valid high for exactly 1 cycle;
- load o_usr_rx_data and both error flags;
- return to IDLE.
REQ-015 Data and flags SHALL hold their values until the next valid strobe.
REQ-016 Frames with a frame error or parity error SHALL still be delivered, with the flag set.
REQ-017 o_rx_check_err SHALL always be 0 when P_UART_CHECK=0.
REQ-018 There is no backpressure; the consumer SHALL accept data in the strobe cycle.
REQ-019 After a frame error, the line held low (break) SHALL NOT produce a new frame until the line returns high and then falls again.
REQ-020 A falling edge in the cycle immediately after return to IDLE SHALL be accepted (back-to-back frames).
REQ-021 Input glitches shorter than H cycles that end high at the START sample SHALL be rejected per REQ-010.

Reset
REQ-022 While i_rst is high, the block SHALL be in IDLE.
REQ-023 While i_rst is high, synchronizer flops and the previous-sample register SHALL read 1.
REQ-024 While i_rst is high, counters and the shift register SHALL be 0.
REQ-025 While i_rst is high, all outputs SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no valid strobe.
REQ-027 After reset release, the next accepted frame SHALL require a fresh high-to-low edge.

Verification
Configuration for all scenarios: P_UART_CLK=50_000_000, P_UART_BAUDRATE=115200, so D=434 and H=217. A line of the form "stimulus -> response" gives the required response to the stimulus.
REQ-028 Mode 0, 1 stop bit, frame with data 0xA5 -> one valid pulse, data=0xA5, both error flags 0, pulse 1 cycle after the stop sample.
REQ-029 Mode 1 (odd), data 0x03, parity bit 1 -> data=0x03, check_err=0. Same data with parity bit 0 -> check_err=1.
REQ-030 Mode 2 (even), 2 stop bits, data 0xFF, second stop bit driven 0 -> data=0xFF, frame_err=1, check_err=0. Then hold the line low for 3 frame times -> no further valid pulse.
REQ-031 Line low for 100 cycles, then high -> no valid pulse and FSM back in IDLE. Then send 0x5A -> data=0x5A.
REQ-032 Frames 0x00, 0xFF and 0x81 back-to-back, each starting on the stop-bit end -> exactly 3 valid pulses, in order, all error flags 0.
REQ-033 Assert i_rst during data bit 4 of a frame -> no valid pulse and outputs 0. Release reset, then send 0x3C -> data=0x3C.
